// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// start_i is held high by EX until ready_o is seen; annul_i cancels; stallreq_o asks ctrl to freeze the front end.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;
    logic [1:0]            state_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o, state_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o, state_o
    );
endinterface

// File: rtl/div_unit.sv
// Restoring divider, one quotient bit per cycle; result_o = {remainder, quotient}.
// Signed operands are divided as magnitudes and the signs are fixed up on the final edge.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     dividend_q, dividend_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quot_q, quot_d;
    logic                  quot_neg_q, quot_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    // One DATA_W+1 wide step: the shifted remainder can exceed DATA_W bits.
    logic [DATA_W:0]       shifted;
    logic [DATA_W:0]       diff;
    logic                  ge;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign shifted  = {rem_q, dividend_q[DATA_W-1]};
    assign diff     = shifted - {1'b0, divisor_q};
    assign ge       = (shifted >= {1'b0, divisor_q});
    assign quot_fix = quot_neg_q ? (~quot_q + 1'b1) : quot_q;
    assign rem_fix  = rem_neg_q  ? (~rem_q  + 1'b1) : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quot_d  = '0;
                        if (bus.signed_div_i) begin
                            dividend_d = bus.opdata1_i[DATA_W-1] ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
                            divisor_d  = bus.opdata2_i[DATA_W-1] ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
                            quot_neg_d = bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1];
                            rem_neg_d  = bus.opdata1_i[DATA_W-1];
                        end else begin
                            dividend_d = bus.opdata1_i;
                            divisor_d  = bus.opdata2_i;
                            quot_neg_d = 1'b0;
                            rem_neg_d  = 1'b0;
                        end
                    end
                end
            end
            BYZERO: begin
                state_d  = END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d  = END;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end else begin
                    rem_d      = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                    quot_d     = {quot_q[DATA_W-2:0], ge};
                    dividend_d = {dividend_q[DATA_W-2:0], 1'b0};
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            END: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus random divides compared against an arithmetic reference.
module tb_div_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_unit_if #(.DATA_W(32)) ifc ();

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        res = '0;
        if (b != 32'd0) begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = sa / sb;
                sr = sa % sb;
                res = {sr[31:0], sq[31:0]};
            end else begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                uq = ua / ub;
                ur = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full divide with start held until ready; operands are scrambled while busy.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          cycles;
        int          stall_cnt;
        logic [63:0] exp_res;
        logic [63:0] exp_q[$];
        exp_q.push_back(ref_div(s, a, b));
        @(negedge clk);
        ifc.signed_div_i = s;
        ifc.opdata1_i    = a;
        ifc.opdata2_i    = b;
        ifc.start_i      = 1'b1;
        ifc.annul_i      = 1'b0;
        cycles    = 0;
        stall_cnt = 0;
        #1;
        if (ifc.stallreq_o) stall_cnt++;
        while (!ifc.ready_o && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (ifc.stallreq_o) stall_cnt++;
            if (cycles > 1 && b != 32'd0) begin
                ifc.opdata1_i = $urandom;
                ifc.opdata2_i = $urandom;
            end
        end
        exp_res = exp_q.pop_front();
        check({tag, " latency"}, 64'(cycles), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, " stall_cycles"}, 64'(stall_cnt), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, " result"}, ifc.result_o, exp_res);
        @(negedge clk);
        check({tag, " hold"}, {ifc.result_o[62:0], ifc.ready_o}, {exp_res[62:0], 1'b1});
        ifc.start_i = 1'b0;
        #1;
        check({tag, " stall_low"}, 64'(ifc.stallreq_o), 64'd0);
        @(negedge clk);
        check({tag, " idle"}, {ifc.result_o[62:0], ifc.ready_o}, 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        ifc.signed_div_i = 1'b0;
        ifc.opdata1_i    = '0;
        ifc.opdata2_i    = '0;
        ifc.start_i      = 1'b0;
        ifc.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset result", ifc.result_o, 64'd0);
        check("reset ready", 64'(ifc.ready_o), 64'd0);
        check("reset stall", 64'(ifc.stallreq_o), 64'd0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, "u100_7");
        check("u100_7 const", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, "s-7_2");
        run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, "s7_-2");
        run_div(1'b0, 32'h12345678, 32'h0, "u_by0");
        run_div(1'b1, 32'h12345678, 32'h0, "s_by0");
        run_div(1'b0, 32'hFFFFFFFF, 32'h1, "umax_1");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");

        // Abort after ten ON cycles; stall must drop in the annul cycle.
        @(negedge clk);
        ifc.signed_div_i = 1'b0;
        ifc.opdata1_i    = 32'd100;
        ifc.opdata2_i    = 32'd7;
        ifc.start_i      = 1'b1;
        repeat (11) @(negedge clk);
        ifc.annul_i = 1'b1;
        #1;
        check("abort stall", 64'(ifc.stallreq_o), 64'd0);
        @(negedge clk);
        check("abort state", {ifc.result_o[62:0], ifc.ready_o}, 64'd0);
        ifc.annul_i = 1'b0;
        ifc.start_i = 1'b0;
        @(negedge clk);
        check("abort quiet", 64'(ifc.ready_o), 64'd0);
        run_div(1'b0, 32'd20, 32'd3, "u20_3");

        // Synchronous reset in the middle of a divide.
        @(negedge clk);
        ifc.signed_div_i = 1'b1;
        ifc.opdata1_i    = 32'd1000;
        ifc.opdata2_i    = 32'd9;
        ifc.start_i      = 1'b1;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", {ifc.result_o[62:0], ifc.ready_o}, 64'd0);
        ifc.start_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b1, 32'd1000, 32'd9, "after_rst");
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            bit          s;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
                default: b = $urandom;
            endcase
            run_div(s, a, b, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
